sad_accumulator: RTL

SAD_ACCUMULATOR -- requirements
Module: sad_accumulator

---
 rtl/sad_pkg.sv | 14 +
 rtl/sad_sat_add.sv | 19 +
 rtl/sad_accumulator.sv | 122 ++++++++++++
 3 files changed

// File: rtl/sad_pkg.sv
// Shared definitions for the SAD accumulator: FSM encoding, saturation ceiling and default sizes.
package sad_pkg;

    typedef enum logic [1:0] {
        SAD_IDLE  = 2'd0,
        SAD_ACCUM = 2'd1,
        SAD_DONE  = 2'd2
    } sad_state_t;

    localparam logic [31:0] SAD_SAT_MAX         = 32'hFFFF_FFFF;
    localparam int          SAD_WINDOW_SIZE_DEF = 16;
    localparam int          SAD_IDX_W_DEF       = 16;

endpackage

// File: rtl/sad_sat_add.sv
// Combinational 32-bit unsigned adder that clamps at SAD_SAT_MAX instead of wrapping.
module sad_sat_add
    import sad_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);

    function automatic logic [31:0] sat33(input logic [32:0] s);
        return s[32] ? SAD_SAT_MAX : s[31:0];
    endfunction

    logic [32:0] wide;

    assign wide = {1'b0, a} + {1'b0, b};
    assign sum  = sat33(wide);

endmodule

// File: rtl/sad_accumulator.sv
// Windowed sum-of-absolute-differences accumulator with optional best-window tracking.
// Define SAD_MIN_TRACK_EN to build the minimum-SAD / window-index tracking logic.
module sad_accumulator
    import sad_pkg::*;
#(
    parameter int WINDOW_SIZE = SAD_WINDOW_SIZE_DEF,
    parameter int IDX_W       = SAD_IDX_W_DEF
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic             InValid,
    input  logic [31:0]      AbsDiff,
    input  logic             ClearMin,
    output logic             InReady,
    output logic             Busy,
    output logic [31:0]      SadOut,
    output logic             SadValid,
    output logic [31:0]      MinSad,
    output logic [IDX_W-1:0] MinIndex,
    output logic             MinValid
);

    localparam int               CNT_W    = $clog2(WINDOW_SIZE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW_SIZE - 1);

    sad_state_t       state;
    logic [31:0]      acc;
    logic [31:0]      acc_sum;
    logic [CNT_W-1:0] count;

    sad_sat_add u_sat_add (
        .a   (acc),
        .b   (AbsDiff),
        .sum (acc_sum)
    );

    assign InReady = (state == SAD_ACCUM);
    assign Busy    = (state == SAD_ACCUM) || (state == SAD_DONE);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= SAD_IDLE;
            acc      <= '0;
            count    <= '0;
            SadOut   <= '0;
            SadValid <= 1'b0;
        end else begin
            SadValid <= 1'b0;
            case (state)
                SAD_IDLE: begin
                    if (Start) begin
                        state <= SAD_ACCUM;
                        acc   <= '0;
                        count <= '0;
                    end
                end
                SAD_ACCUM: begin
                    // A restart wins over a sample presented in the same cycle
                    if (Start) begin
                        acc   <= '0;
                        count <= '0;
                    end else if (InValid) begin
                        acc <= acc_sum;
                        if (count == CNT_LAST) begin
                            state <= SAD_DONE;
                            count <= '0;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                SAD_DONE: begin
                    SadOut   <= acc;
                    SadValid <= 1'b1;
                    if (Start) begin
                        state <= SAD_ACCUM;
                        acc   <= '0;
                        count <= '0;
                    end else begin
                        state <= SAD_IDLE;
                    end
                end
                default: state <= SAD_IDLE;
            endcase
        end
    end

`ifdef SAD_MIN_TRACK_EN
    logic [IDX_W-1:0] index;

    // ClearMin is applied before the DONE comparison, so a coinciding window becomes index 0
    always_ff @(posedge Clk) begin
        if (Rst) begin
            MinSad   <= '0;
            MinIndex <= '0;
            MinValid <= 1'b0;
            index    <= '0;
        end else if (state == SAD_DONE) begin
            if (ClearMin || !MinValid || (acc < MinSad)) begin
                MinSad   <= acc;
                MinIndex <= ClearMin ? '0 : index;
                MinValid <= 1'b1;
            end
            index <= ClearMin ? IDX_W'(1) : index + 1'b1;
        end else if (ClearMin) begin
            MinSad   <= '0;
            MinIndex <= '0;
            MinValid <= 1'b0;
            index    <= '0;
        end
    end
`else
    logic unused_clearmin;

    assign unused_clearmin = ClearMin;
    assign MinSad          = '0;
    assign MinIndex        = '0;
    assign MinValid        = 1'b0;
`endif

endmodule
